// File: rtl/led_seq_scheduler.sv
// LED pattern sequencer: input sync, button debounce/click, step prescaler and run FSM.
// Optional SEQ_AUTO_MODE_EN: auto mode advance after AUTO_STEPS step pulses in RUN.
module led_seq_scheduler #(
    parameter int unsigned TICK_DIV   = 8000000,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned NUM_MODES  = 2,
    parameter int unsigned AUTO_STEPS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       run_sw,
    input  logic [1:0] speed,
    output logic       step_en,
    output logic       restart,
    output logic [1:0] mode,
    output logic [1:0] state_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    logic          btn_s1, btn_s2, run_s1, run_s2;
    logic [DW-1:0] deb_cnt;
    logic          deb_lvl;
    logic          click;
    logic [CW-1:0] pre_cnt;
    logic [31:0]   period;
    logic          tick;
    logic [1:0]    mode_nx;

`ifdef SEQ_AUTO_MODE_EN
    localparam int unsigned SW = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
    logic [SW-1:0] step_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_in;
            btn_s2 <= btn_s1;
            run_s1 <= run_sw;
            run_s2 <= run_s1;
        end
    end

    // click is registered alongside the debounced level, so it is high in the first cycle the level reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
            click   <= 1'b0;
        end else begin
            click <= 1'b0;
            if (btn_s2 != deb_lvl) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    deb_lvl <= btn_s2;
                    deb_cnt <= '0;
                    click   <= deb_lvl;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        period = TICK_DIV >> speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        tick    = (32'(pre_cnt) >= period - 32'd1);
        mode_nx = (mode == 2'(NUM_MODES - 1)) ? '0 : mode + 2'd1;
    end

    // Pulses are decoded from registered state so run_sw=0 > click > tick resolves within the same cycle
    assign step_en = (state == RUN) && run_s2 && !click && tick;
    assign restart = (state == START) && run_s2;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= '0;
            pre_cnt <= '0;
`ifdef SEQ_AUTO_MODE_EN
            step_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pre_cnt <= '0;
`ifdef SEQ_AUTO_MODE_EN
                    step_cnt <= '0;
`endif
                    if (click) begin
                        mode <= mode_nx;
                    end
                    if (run_s2) begin
                        state <= START;
                    end
                end
                START: begin
                    pre_cnt <= '0;
`ifdef SEQ_AUTO_MODE_EN
                    step_cnt <= '0;
`endif
                    state <= run_s2 ? RUN : IDLE;
                end
                RUN: begin
                    if (!run_s2) begin
                        state   <= IDLE;
                        pre_cnt <= '0;
                    end else if (click) begin
                        mode    <= mode_nx;
                        state   <= START;
                        pre_cnt <= '0;
`ifdef SEQ_AUTO_MODE_EN
                        step_cnt <= '0;
`endif
                    end else if (tick) begin
                        pre_cnt <= '0;
`ifdef SEQ_AUTO_MODE_EN
                        if (step_cnt == SW'(AUTO_STEPS - 1)) begin
                            step_cnt <= '0;
                            mode     <= mode_nx;
                            state    <= START;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
`endif
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pre_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_scheduler.sv
// Scoreboard bench for led_seq_scheduler: expected restart/step pulses are queued with their cycle numbers.
module tb_led_seq_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       run_sw = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       step_en, restart;
    logic [1:0] mode, state_o;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int kind;   // 0 restart, 1 step
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    led_seq_scheduler #(
        .TICK_DIV(8),
        .DEB_CYCLES(4),
        .NUM_MODES(2),
        .AUTO_STEPS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .run_sw(run_sw),
        .speed(speed),
        .step_en(step_en),
        .restart(restart),
        .mode(mode),
        .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.cyc = t;
        exp_q.push_back(e);
    endfunction

    function automatic void push_steps(input int first, input int p, input int last);
        for (int t = first; t <= last; t += p) push_ev(1, t);
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) next();
    endtask

    // Scoreboard: every pulse seen must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && (restart || step_en)) begin
            ev_t e;
            int k;
            k = restart ? 0 : 1;
            n_checks++;
            if (restart && step_en) begin
                n_fail++;
                $display("FAIL overlap: restart=%0b step_en=%0b at cycle %0d, required not both", restart, step_en, cyc);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== k || e.cyc !== cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d", k, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        goto(3);
        n_checks++;
        if (step_en !== 1'b0 || restart !== 1'b0 || mode !== 2'd0 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: step_en=%0b restart=%0b mode=%0d state=%0d, required all 0", step_en, restart, mode, state_o);
        end
        rst_n = 1'b1;
        goto(8);
        n_checks++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: state=%0d, required 0", state_o);
        end
    endtask

    task automatic drain(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: %0d pulses outstanding, next kind %0d at cycle %0d, required 0", name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_start_step();
        int c;
        c = cyc;
        speed = 2'd0;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 11, 8, c + 31);
        goto(c + 30);
        n_checks++;
        if (state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL start_run_state: state=%0d, required 2", state_o);
        end
        run_sw = 1'b0;
        goto(c + 34);
        n_checks++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL stop_state: state=%0d, required 0", state_o);
        end
        c = cyc;
        speed = 2'd2;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 5, 2, c + 11);
        goto(c + 10);
        run_sw = 1'b0;
        goto(c + 14);
        speed = 2'd0;
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL start_mode: mode=%0d, required 0", mode);
        end
        drain("start_step");
    endtask

    task automatic test_debounce();
        int c;
        c = cyc;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 11, 8, c + 27);
        push_ev(0, c + 29);
        push_steps(c + 37, 8, c + 47);
        goto(c + 5);
        btn_in = 1'b1;
        goto(c + 8);
        btn_in = 1'b0;
        goto(c + 12);
        btn_in = 1'b1;
        goto(c + 22);
        btn_in = 1'b0;
        goto(c + 28);
        n_checks++;
        if (mode !== 2'd0 || state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL glitch_ignored: mode=%0d state=%0d, required mode 0 state 2", mode, state_o);
        end
        goto(c + 29);
        n_checks++;
        if (mode !== 2'd1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL click_advance: mode=%0d state=%0d, required mode 1 state 1", mode, state_o);
        end
        goto(c + 46);
        run_sw = 1'b0;
        goto(c + 50);
        n_checks++;
        if (state_o !== 2'd0 || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL debounce_stop: state=%0d mode=%0d, required state 0 mode 1", state_o, mode);
        end
        drain("debounce");
    endtask

    task automatic test_wrap_priority();
        int c;
        c = cyc;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 11, 8, c + 19);
        push_ev(0, c + 22);
        push_steps(c + 30, 8, c + 39);
        goto(c + 5);
        btn_in = 1'b1;
        goto(c + 15);
        btn_in = 1'b0;
        goto(c + 22);
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL mode_wrap: mode=%0d, required 0", mode);
        end
        goto(c + 24);
        btn_in = 1'b1;
        goto(c + 34);
        btn_in = 1'b0;
        goto(c + 38);
        run_sw = 1'b0;
        goto(c + 40);
        n_checks++;
        if (state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_pre_state: state=%0d, required 2", state_o);
        end
        goto(c + 41);
        n_checks++;
        if (state_o !== 2'd0 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL prio_click_discard: state=%0d mode=%0d, required state 0 mode 0", state_o, mode);
        end
        goto(c + 44);
        btn_in = 1'b1;
        goto(c + 54);
        btn_in = 1'b0;
        goto(c + 60);
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_click_early: mode=%0d, required 0", mode);
        end
        goto(c + 61);
        n_checks++;
        if (mode !== 2'd1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_click: mode=%0d state=%0d, required mode 1 state 0", mode, state_o);
        end
        goto(c + 64);
        drain("wrap_priority");
    endtask

    task automatic test_speed_change();
        int c;
        c = cyc;
        speed = 2'd0;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 9, 2, c + 17);
        goto(c + 9);
        speed = 2'd2;
        goto(c + 16);
        run_sw = 1'b0;
        goto(c + 20);
        speed = 2'd0;
        n_checks++;
        if (state_o !== 2'd0 || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL speed_stop: state=%0d mode=%0d, required state 0 mode 1", state_o, mode);
        end
        drain("speed_change");
    endtask

`ifdef SEQ_AUTO_MODE_EN
    task automatic test_auto_mode();
        int c;
        c = cyc;
        speed = 2'd3;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_steps(c + 4, 1, c + 6);
        push_ev(0, c + 7);
        push_steps(c + 8, 1, c + 10);
        push_ev(0, c + 11);
        push_steps(c + 12, 1, c + 13);
        goto(c + 7);
        n_checks++;
        if (mode !== 2'd1) begin
            n_fail++;
            $display("FAIL auto_advance: mode=%0d, required 1", mode);
        end
        goto(c + 11);
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL auto_wrap: mode=%0d, required 0", mode);
        end
        goto(c + 12);
        run_sw = 1'b0;
        goto(c + 16);
        speed = 2'd0;
        drain("auto_mode");
    endtask
`endif

    task automatic test_reset_mid_run();
        int c;
        c = cyc;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        push_ev(1, c + 11);
        goto(c + 14);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (step_en !== 1'b0 || restart !== 1'b0 || mode !== 2'd0 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: step_en=%0b restart=%0b mode=%0d state=%0d, required all 0", step_en, restart, mode, state_o);
        end
        run_sw = 1'b0;
        goto(c + 18);
        rst_n = 1'b1;
        goto(c + 24);
        n_checks++;
        if (state_o !== 2'd0 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d mode=%0d, required state 0 mode 0", state_o, mode);
        end
        c = cyc;
        run_sw = 1'b1;
        push_ev(0, c + 3);
        goto(c + 5);
        n_checks++;
        if (state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL rerun_state: state=%0d, required 2", state_o);
        end
        run_sw = 1'b0;
        goto(c + 9);
        drain("reset_mid_run");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef SEQ_AUTO_MODE_EN
        test_auto_mode();
`else
        test_start_step();
        test_debounce();
        test_wrap_priority();
        test_speed_change();
`endif
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_scheduler.md
Name: led_seq_scheduler

Overview:
- Sequences the LED pattern datapath on the board.
- Debounces the centre button and turns a release into a mode-advance click.
- Generates the step tick from a programmable prescaler and issues restart pulses so the datapath reloads its start position.
- Sits between the board I/O (btnC, sw) and the pattern/LED decode datapath.

Parameters:
TICK_DIV, 8000000, base step period in clk cycles (speed=0)
DEB_CYCLES, 250000, consecutive stable cycles required to accept a new button level
NUM_MODES, 2, number of pattern modes; mode wraps NUM_MODES-1 -> 0
AUTO_STEPS, 32, step_en pulses per mode before auto-advance (used only with SEQ_AUTO_MODE_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
btn_in  in  1  raw centre button (asynchronous)
run_sw  in  1  raw run switch (asynchronous); 1 = run, 0 = hold
speed  in  2  step-rate select; period = max(TICK_DIV >> speed, 1)
step_en  out  1  one-cycle pulse: datapath advances one step
restart  out  1  one-cycle pulse: datapath loads start position
mode  out  2  current pattern mode, 0..NUM_MODES-1
state_o  out  2  FSM state: 0 IDLE, 1 START, 2 RUN

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM=IDLE, prescaler=0, debounced level=0, sync flops=0.
- Input sync: btn_in and run_sw each pass through a 2-flop synchroniser. All logic below uses synced values.
- Debounce:
  - The counter increments while synced btn differs from the debounced level and clears when they match.
  - When the count reaches DEB_CYCLES-1, the debounced level takes the synced value and the counter clears.
- Click: a one-cycle pulse on the debounced falling edge (on release).
- Prescaler:
  - Counts 0..P-1, with P = max(TICK_DIV>>speed, 1).
  - tick=1 when count==P-1; count then returns to 0.
  - If speed changes so that count >= P-1, tick fires on the next cycle and count wraps.
  - Held at 0 outside RUN.
- FSM:
  - IDLE: step_en=0. If run_sw=1, go to START. A click advances mode; no restart pulse.
  - START: restart=1 for exactly this cycle; prescaler cleared; go to RUN next cycle. If run_sw=0, go to IDLE instead, with no restart pulse.
  - RUN, on tick: step_en=1 that cycle.
  - RUN, on click: mode advances (wrap), go to START; no step_en that cycle.
  - RUN, on run_sw=0: go to IDLE; mode retained; no pulse.
- Priority within one cycle: run_sw=0 > click > tick.
  - Click coincident with run_sw falling in RUN: click discarded, mode unchanged.
- Latency:
  - run_sw raw rise to restart: 3 clk (2 sync + 1 IDLE->START).
  - First step_en exactly P cycles after the restart cycle, then every P cycles.
- restart and step_en are never high in the same cycle.
- Reset mid-RUN: immediate return to reset values. The datapath sees no pulse.

Optional Feature:
- Macro: SEQ_AUTO_MODE_EN.
- Defined:
  - A step counter counts step_en pulses in RUN.
  - On the AUTO_STEPS-th pulse the mode advances (wrap) and the FSM goes to START (restart next cycle). That step_en is still issued.
  - The step counter clears on START, IDLE, click and reset.
- Undefined: no step counter; mode changes only on click.

Test Plan:
- Setup: TICK_DIV=8, DEB_CYCLES=4, NUM_MODES=2.
- Reset: rst_n=0 mid-RUN -> step_en=0, restart=0, mode=0, state_o=0 asynchronously; these hold until run_sw rises after release.
- Start/step: run_sw 0->1, speed=0 -> restart pulse 3 clk after edge; step_en at restart+8, +16, +24; speed=2 -> period 2.
- Debounce: btn glitch high for 3 clk -> no click. Btn held 10 clk then released stable -> exactly one click; mode 0->1, restart pulse, step spacing restarts from 8.
- Wrap/priority: mode=1, click -> mode=0. Click arriving in the same cycle run_sw sync falls -> state IDLE, mode unchanged, no restart.
- Speed change: count=5 at speed=0, set speed=2 (P=2) -> step_en next cycle, then every 2 cycles.
- SEQ_AUTO_MODE_EN, AUTO_STEPS=3: RUN at speed=3 (P=1) -> 3 step_en pulses, mode increments, restart the cycle after the 3rd step, then the count restarts.
